seg7_readback_decoder: RTL and testbench



---
 rtl/seg7_readback_decoder.sv | 131 +++++++++++++
 tb/tb_seg7_readback_decoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seg7_readback_decoder.sv
// Recovers a 16-bit hex value from four active-low seven-segment digit buses,
// filtering each digit for stability and flagging blank/illegal glyphs.
module seg7_readback_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  hex_in0,
    input  logic [6:0]  hex_in1,
    input  logic [6:0]  hex_in2,
    input  logic [6:0]  hex_in3,
    output logic [15:0] hex_data,
    output logic [3:0]  digit_stable,
    output logic [3:0]  digit_invalid,
    output logic [3:0]  digit_blank,
    output logic        data_valid,
    output logic        change_strobe
);

    localparam int              CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0]      BLANK   = 7'b1111111;

    // Returns {legal, nibble}; legal is clear for blank and unknown patterns.
    function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0010000: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b0001110: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    logic [3:0][6:0]       hex_in;
    logic [3:0][6:0]       samp_q, samp_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]           hex_data_q, hex_data_d;
    logic [3:0]            stable_q, stable_d;
    logic [3:0]            invalid_q, invalid_d;
    logic [3:0]            blank_q, blank_d;
    logic                  data_valid_q, data_valid_d;
    logic                  change_strobe_q, change_strobe_d;
    logic [4:0]            glyph;

    assign hex_in = {hex_in3, hex_in2, hex_in1, hex_in0};

    always_comb begin
        samp_d     = hex_in;
        cnt_d      = cnt_q;
        hex_data_d = hex_data_q;
        stable_d   = stable_q;
        invalid_d  = invalid_q;
        blank_d    = blank_q;
        glyph      = '0;
        for (int i = 0; i < 4; i++) begin
            glyph = decode_glyph(samp_q[i]);
            if (hex_in[i] != samp_q[i]) begin
                cnt_d[i]    = '0;
                stable_d[i] = 1'b0;
            end else begin
                cnt_d[i] = sat_inc(cnt_q[i]);
                // Saturated counter re-accepts every cycle; identical values cause no strobe.
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = 1'b1;
                    if (glyph[4]) begin
                        hex_data_d[4*i +: 4] = glyph[3:0];
                        invalid_d[i]         = 1'b0;
                        blank_d[i]           = 1'b0;
                    end else if (samp_q[i] == BLANK) begin
                        invalid_d[i] = 1'b0;
                        blank_d[i]   = 1'b1;
                    end else begin
                        invalid_d[i] = 1'b1;
                        blank_d[i]   = 1'b0;
                    end
                end
            end
        end
        data_valid_d    = (&stable_d) & ~(|invalid_d) & ~(|blank_d);
        change_strobe_d = ({hex_data_d, invalid_d, blank_d} != {hex_data_q, invalid_q, blank_q});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_q          <= {4{BLANK}};
            cnt_q           <= '0;
            hex_data_q      <= '0;
            stable_q        <= '0;
            invalid_q       <= '0;
            blank_q         <= '0;
            data_valid_q    <= 1'b0;
            change_strobe_q <= 1'b0;
        end else begin
            samp_q          <= samp_d;
            cnt_q           <= cnt_d;
            hex_data_q      <= hex_data_d;
            stable_q        <= stable_d;
            invalid_q       <= invalid_d;
            blank_q         <= blank_d;
            data_valid_q    <= data_valid_d;
            change_strobe_q <= change_strobe_d;
        end
    end

    assign hex_data      = hex_data_q;
    assign digit_stable  = stable_q;
    assign digit_invalid = invalid_q;
    assign digit_blank   = blank_q;
    assign data_valid    = data_valid_q;
    assign change_strobe = change_strobe_q;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed bench for seg7_readback_decoder: default filter depth plus a
// second instance with STABLE_CYCLES=2 for the full glyph sweep.
module tb_seg7_readback_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  hex_in0, hex_in1, hex_in2, hex_in3;
    logic [15:0] hex_data;
    logic [3:0]  digit_stable, digit_invalid, digit_blank;
    logic        data_valid, change_strobe;

    logic [6:0]  hex2_in0, hex2_in1, hex2_in2, hex2_in3;
    logic [15:0] hex2_data;
    logic [3:0]  stable2, invalid2, blank2;
    logic        valid2, strobe2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] glyph_pat [16];

    seg7_readback_decoder #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .hex_in0(hex_in0), .hex_in1(hex_in1), .hex_in2(hex_in2), .hex_in3(hex_in3),
        .hex_data(hex_data), .digit_stable(digit_stable), .digit_invalid(digit_invalid),
        .digit_blank(digit_blank), .data_valid(data_valid), .change_strobe(change_strobe)
    );

    seg7_readback_decoder #(.STABLE_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset),
        .hex_in0(hex2_in0), .hex_in1(hex2_in1), .hex_in2(hex2_in2), .hex_in3(hex2_in3),
        .hex_data(hex2_data), .digit_stable(stable2), .digit_invalid(invalid2),
        .digit_blank(blank2), .data_valid(valid2), .change_strobe(strobe2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        glyph_pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        hex_in0 = 7'h7F; hex_in1 = 7'h7F; hex_in2 = 7'h7F; hex_in3 = 7'h7F;
        hex2_in0 = 7'h7F; hex2_in1 = 7'h7F; hex2_in2 = 7'h7F; hex2_in3 = 7'h7F;

        // Reset state
        step(1);
        check_eq("rst_data",   32'(hex_data), 0);
        check_eq("rst_stable", 32'(digit_stable), 0);
        check_eq("rst_inv",    32'(digit_invalid), 0);
        check_eq("rst_blank",  32'(digit_blank), 0);
        check_eq("rst_valid",  32'(data_valid), 0);
        check_eq("rst_strobe", 32'(change_strobe), 0);
        reset = 1'b0;

        // 3210 acceptance latency
        hex_in3 = 7'b0110000; hex_in2 = 7'b0100100; hex_in1 = 7'b1111001; hex_in0 = 7'b1000000;
        step(4);
        check_eq("e3_data",   32'(hex_data), 0);
        check_eq("e3_stable", 32'(digit_stable), 0);
        check_eq("e3_strobe", 32'(change_strobe), 0);
        step(1);
        check_eq("e4_data",   32'(hex_data), 32'h3210);
        check_eq("e4_stable", 32'(digit_stable), 32'hF);
        check_eq("e4_valid",  32'(data_valid), 1);
        check_eq("e4_strobe", 32'(change_strobe), 1);
        step(1);
        check_eq("e5_strobe", 32'(change_strobe), 0);

        // 3-sample glitch on digit 0
        hex_in0 = 7'b0000000;
        step(1);
        check_eq("gl_stable", 32'(digit_stable), 32'hE);
        check_eq("gl_valid",  32'(data_valid), 0);
        check_eq("gl_strobe", 32'(change_strobe), 0);
        step(2);
        check_eq("gl_data",   32'(hex_data), 32'h3210);
        check_eq("gl_strobe2", 32'(change_strobe), 0);
        hex_in0 = 7'b1000000;
        step(4);
        check_eq("rs_stable3", 32'(digit_stable), 32'hE);
        check_eq("rs_strobe3", 32'(change_strobe), 0);
        step(1);
        check_eq("rs_stable4", 32'(digit_stable), 32'hF);
        check_eq("rs_valid",   32'(data_valid), 1);
        check_eq("rs_data",    32'(hex_data), 32'h3210);
        check_eq("rs_strobe",  32'(change_strobe), 0);

        // Blank digit 2, then digit 1
        hex_in2 = 7'h7F;
        step(5);
        check_eq("bl2_blank",  32'(digit_blank), 32'h4);
        check_eq("bl2_valid",  32'(data_valid), 0);
        check_eq("bl2_data",   32'(hex_data), 32'h3210);
        check_eq("bl2_strobe", 32'(change_strobe), 1);
        hex_in1 = 7'h7F;
        step(5);
        check_eq("bl1_blank",  32'(digit_blank), 32'h6);
        check_eq("bl1_data",   32'(hex_data), 32'h3210);

        // Restore digit 2, make digit 1 an illegal pattern
        hex_in2 = 7'b0100100; hex_in1 = 7'b0101010;
        step(5);
        check_eq("inv_inv",    32'(digit_invalid), 32'h2);
        check_eq("inv_blank",  32'(digit_blank), 0);
        check_eq("inv_valid",  32'(data_valid), 0);
        check_eq("inv_data",   32'(hex_data), 32'h3210);
        check_eq("inv_strobe", 32'(change_strobe), 1);
        step(1);
        check_eq("inv_strobe_end", 32'(change_strobe), 0);
        hex_in1 = 7'b0000011;
        step(5);
        check_eq("b_data",   32'(hex_data), 32'h32B0);
        check_eq("b_inv",    32'(digit_invalid), 0);
        check_eq("b_valid",  32'(data_valid), 1);
        check_eq("b_strobe", 32'(change_strobe), 1);
        step(1);
        check_eq("b_strobe_end", 32'(change_strobe), 0);

        // All 16 glyphs through digit 3 of the 2-cycle instance
        for (int g = 0; g < 16; g++) begin
            hex2_in3 = glyph_pat[g];
            step(2);
            check_eq($sformatf("sweep_early_%0d", g), 32'(hex2_data[15:12]), (g == 0) ? 0 : g - 1);
            step(1);
            check_eq($sformatf("sweep_%0d", g), 32'(hex2_data[15:12]), g);
        end
        check_eq("sweep_blank", 32'(blank2), 32'h7);

        // Reset partway through a count
        hex_in0 = 7'b1111001;
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_eq("mr_data",   32'(hex_data), 0);
        check_eq("mr_stable", 32'(digit_stable), 0);
        check_eq("mr_inv",    32'(digit_invalid), 0);
        check_eq("mr_blank",  32'(digit_blank), 0);
        check_eq("mr_valid",  32'(data_valid), 0);
        check_eq("mr_strobe", 32'(change_strobe), 0);
        step(4);
        check_eq("mr_p3_data",   32'(hex_data), 0);
        check_eq("mr_p3_stable", 32'(digit_stable), 0);
        step(1);
        check_eq("mr_p4_data",   32'(hex_data), 32'h32B1);
        check_eq("mr_p4_valid",  32'(data_valid), 1);
        check_eq("mr_p4_strobe", 32'(change_strobe), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
